// File: rtl/ad9912_writer.sv
// AD9912 SPI writer: shadows frequency/phase/amplitude updates, streams them as
// SPI writes, pulses io_update after a flush, and sequences the DDS power-up reset.
module ad9912_writer #(
  parameter int unsigned W_FREQ     = 48,
  parameter int unsigned W_PHASE    = 14,
  parameter int unsigned W_AMP      = 10,
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned RST_CYCLES = 64,
  parameter int unsigned INIT_WAIT  = 256,
  parameter int unsigned CSB_GAP    = 2,
  parameter int unsigned IOU_CYCLES = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [W_FREQ-1:0]  freq_in,
  input  logic [W_PHASE-1:0] phase_in,
  input  logic [W_AMP-1:0]   amp_in,
  input  logic               freq_dv_in,
  input  logic               phase_dv_in,
  input  logic               amp_dv_in,
  output logic               sclk_out,
  output logic               reset_out,
  output logic               csb_out,
  output logic               sdio_out,
  output logic               io_update_out,
  output logic               busy_out
);

  localparam int unsigned GAP_CYCLES = CSB_GAP * SCLK_DIV;
  localparam int unsigned M1 = (RST_CYCLES > INIT_WAIT) ? RST_CYCLES : INIT_WAIT;
  localparam int unsigned M2 = (GAP_CYCLES > IOU_CYCLES) ? GAP_CYCLES : IOU_CYCLES;
  localparam int unsigned M3 = (M1 > M2) ? M1 : M2;
  localparam int unsigned CNT_MAX = (M3 > SCLK_DIV) ? M3 : SCLK_DIV;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] IOU_LAST  = CW'(IOU_CYCLES - 1);

  localparam logic [15:0] INSTR_FREQ  = {1'b0, 2'b11, 13'h01AB};
  localparam logic [15:0] INSTR_PHASE = {1'b0, 2'b11, 13'h01AD};
  localparam logic [15:0] INSTR_AMP   = {1'b0, 2'b11, 13'h040C};

  localparam logic [3:0] ST_RST_HOLD = 4'd0;
  localparam logic [3:0] ST_INIT     = 4'd1;
  localparam logic [3:0] ST_IDLE     = 4'd2;
  localparam logic [3:0] ST_LOAD     = 4'd3;
  localparam logic [3:0] ST_CS_SETUP = 4'd4;
  localparam logic [3:0] ST_SHIFT    = 4'd5;
  localparam logic [3:0] ST_CS_END   = 4'd6;
  localparam logic [3:0] ST_GAP      = 4'd7;
  localparam logic [3:0] ST_IOU      = 4'd8;

  logic [3:0]         state;
  logic [CW-1:0]      cnt;
  logic [W_FREQ-1:0]  freq_sh;
  logic [W_PHASE-1:0] phase_sh;
  logic [W_AMP-1:0]   amp_sh;
  logic               pend_f;
  logic               pend_p;
  logic               pend_a;
  logic               flushed;
  logic [63:0]        sreg;
  logic [6:0]         bits_left;

  logic        sel_f;
  logic        sel_p;
  logic        sel_a;
  logic        in_load;
  logic [47:0] freq_ext;
  logic [15:0] phase_ext;
  logic [15:0] amp_ext;
  logic [63:0] load_word;

  assign busy_out = (state != ST_IDLE);
  assign in_load  = (state == ST_LOAD);

  // Priority select; 32-bit frames are left-justified so sdio always comes from bit 63.
  always_comb begin
    sel_f = pend_f;
    sel_p = ~pend_f & pend_p;
    sel_a = ~pend_f & ~pend_p & pend_a;
    freq_ext = '0;
    freq_ext[W_FREQ-1:0] = freq_sh;
    phase_ext = '0;
    phase_ext[W_PHASE-1:0] = phase_sh;
    amp_ext = '0;
    amp_ext[W_AMP-1:0] = amp_sh;
    if (sel_f)
      load_word = {INSTR_FREQ, freq_ext};
    else if (sel_p)
      load_word = {INSTR_PHASE, phase_ext, 32'h0};
    else
      load_word = {INSTR_AMP, amp_ext, 32'h0};
  end

  // A strobe in the LOAD cycle re-arms the flag the LOAD is clearing.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      freq_sh  <= '0;
      phase_sh <= '0;
      amp_sh   <= '0;
      pend_f   <= 1'b0;
      pend_p   <= 1'b0;
      pend_a   <= 1'b0;
    end else begin
      if (freq_dv_in)  freq_sh  <= freq_in;
      if (phase_dv_in) phase_sh <= phase_in;
      if (amp_dv_in)   amp_sh   <= amp_in;
      pend_f <= freq_dv_in  | (pend_f & ~(in_load & sel_f));
      pend_p <= phase_dv_in | (pend_p & ~(in_load & sel_p));
      pend_a <= amp_dv_in   | (pend_a & ~(in_load & sel_a));
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state         <= ST_RST_HOLD;
      cnt           <= '0;
      reset_out     <= 1'b1;
      csb_out       <= 1'b1;
      sclk_out      <= 1'b0;
      sdio_out      <= 1'b0;
      io_update_out <= 1'b0;
      flushed       <= 1'b0;
      sreg          <= '0;
      bits_left     <= '0;
    end else begin
      case (state)
        ST_RST_HOLD: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            reset_out <= 1'b0;
            state     <= ST_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (pend_f | pend_p | pend_a) begin
            state <= ST_LOAD;
          end else if (flushed) begin
            io_update_out <= 1'b1;
            cnt           <= '0;
            state         <= ST_IOU;
          end
        end
        ST_LOAD: begin
          sreg      <= load_word;
          bits_left <= sel_f ? 7'd64 : 7'd32;
          sdio_out  <= load_word[63];
          csb_out   <= 1'b0;
          flushed   <= 1'b1;
          cnt       <= '0;
          state     <= ST_CS_SETUP;
        end
        ST_CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            sclk_out <= 1'b1;
            state    <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Data moves only with the falling edge; the frame ends after the last low half.
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (sclk_out) begin
              sclk_out  <= 1'b0;
              sreg      <= {sreg[62:0], 1'b0};
              sdio_out  <= sreg[62];
              bits_left <= bits_left - 1'b1;
            end else if (bits_left == 7'd0) begin
              csb_out  <= 1'b1;
              sdio_out <= 1'b0;
              state    <= ST_CS_END;
            end else begin
              sclk_out <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CS_END: begin
          cnt   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IOU: begin
          if (cnt == IOU_LAST) begin
            cnt           <= '0;
            io_update_out <= 1'b0;
            flushed       <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9912_writer.sv
// Self-checking bench for ad9912_writer: SPI frames are decoded off the pins and
// compared with frames predicted from the field/priority rules.
module tb_ad9912_writer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        reset_in;
  logic [47:0] freq_in;
  logic [13:0] phase_in;
  logic [9:0]  amp_in;
  logic        freq_dv_in, phase_dv_in, amp_dv_in;
  logic        sclk_out, reset_out, csb_out, sdio_out, io_update_out, busy_out;

  logic        fast_dv, zero1;
  logic        f_sclk, f_reset, f_csb, f_sdio, f_iou, f_busy;

  ad9912_writer dut (
    .clk_in(clk_in), .reset_in(reset_in), .freq_in(freq_in), .phase_in(phase_in),
    .amp_in(amp_in), .freq_dv_in(freq_dv_in), .phase_dv_in(phase_dv_in),
    .amp_dv_in(amp_dv_in), .sclk_out(sclk_out), .reset_out(reset_out),
    .csb_out(csb_out), .sdio_out(sdio_out), .io_update_out(io_update_out),
    .busy_out(busy_out)
  );

  ad9912_writer #(.SCLK_DIV(1), .RST_CYCLES(4), .INIT_WAIT(8)) u_fast (
    .clk_in(clk_in), .reset_in(reset_in), .freq_in(freq_in), .phase_in(phase_in),
    .amp_in(amp_in), .freq_dv_in(fast_dv), .phase_dv_in(zero1),
    .amp_dv_in(zero1), .sclk_out(f_sclk), .reset_out(f_reset),
    .csb_out(f_csb), .sdio_out(f_sdio), .io_update_out(f_iou),
    .busy_out(f_busy)
  );

  typedef struct {
    logic [63:0] data;
    int unsigned nbits;
    int unsigned low_len;
  } frame_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // main-instance monitor state
  frame_t      got_q[$];
  logic [63:0] cur;
  int unsigned cur_bits, cur_low, csb_falls, iou_pulses, iou_w, iou_last_w;
  int unsigned frames_at_iou, viol, gap_cnt, min_gap;
  logic        p_sclk, p_csb, p_sdio, p_iou;

  // fast-instance monitor state
  logic [63:0] fcur;
  int unsigned fbits, flow, fper, fper_bad, fviol, f_frames;
  logic        fp_sclk, fp_csb, fp_sdio;

  // reference model: shadows, pending set, expected frames
  logic [47:0] m_f;
  logic [13:0] m_p;
  logic [9:0]  m_a;
  logic [2:0]  m_pend;
  frame_t      exp_q[$];
  int unsigned iou_base;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    cur = '0; cur_bits = 0; cur_low = 0; csb_falls = 0; iou_pulses = 0; iou_w = 0;
    iou_last_w = 0; frames_at_iou = 0; viol = 0; gap_cnt = 1000; min_gap = 1000;
    p_sclk = 0; p_csb = 1; p_sdio = 0; p_iou = 0;
    forever begin
      @(negedge clk_in);
      if (!reset_in) begin
        p_sclk = 0; p_csb = 1; p_sdio = 0; p_iou = 0;
        cur_bits = 0; cur_low = 0; iou_w = 0; gap_cnt = 1000;
      end else begin
        if (sdio_out !== p_sdio && sclk_out) viol++;
        if (!csb_out) begin
          if (p_csb) begin
            csb_falls++;
            if (gap_cnt < min_gap) min_gap = gap_cnt;
            cur = '0; cur_bits = 0; cur_low = 0;
          end
          cur_low++;
          if (sclk_out && !p_sclk) begin
            cur = {cur[62:0], sdio_out};
            cur_bits++;
          end
        end else begin
          if (!p_csb) begin
            got_q.push_back('{data: cur, nbits: cur_bits, low_len: cur_low});
            gap_cnt = 0;
          end
          gap_cnt++;
        end
        if (io_update_out) begin
          if (!p_iou) frames_at_iou = got_q.size();
          iou_w++;
        end else if (p_iou) begin
          iou_pulses++;
          iou_last_w = iou_w;
          iou_w = 0;
        end
        p_sclk = sclk_out; p_csb = csb_out; p_sdio = sdio_out; p_iou = io_update_out;
      end
    end
  end

  initial begin
    fcur = '0; fbits = 0; flow = 0; fper = 0; fper_bad = 0; fviol = 0; f_frames = 0;
    fp_sclk = 0; fp_csb = 1; fp_sdio = 0;
    forever begin
      @(negedge clk_in);
      if (!reset_in) begin
        fp_sclk = 0; fp_csb = 1; fp_sdio = 0; fbits = 0;
      end else begin
        if (f_sdio !== fp_sdio && f_sclk) fviol++;
        if (!f_csb) begin
          if (fp_csb) begin fcur = '0; fbits = 0; flow = 0; fper = 0; end
          flow++;
          fper++;
          if (f_sclk && !fp_sclk) begin
            if (fbits != 0 && fper != 2) fper_bad++;
            fper = 0;
            fcur = {fcur[62:0], f_sdio};
            fbits++;
          end
        end else if (!fp_csb) begin
          f_frames++;
        end
        fp_sclk = f_sclk; fp_csb = f_csb; fp_sdio = f_sdio;
      end
    end
  end

  function automatic frame_t exp_frame(input int kind);
    frame_t fr;
    fr.low_len = 0;
    case (kind)
      0:       begin fr.data = {16'h61AB, m_f};               fr.nbits = 64; end
      1:       begin fr.data = {32'h0, 16'h61AD, 2'b00, m_p}; fr.nbits = 32; end
      default: begin fr.data = {32'h0, 16'h640C, 6'h00, m_a}; fr.nbits = 32; end
    endcase
    fr.low_len = (1 + 2 * fr.nbits) * 4;
    return fr;
  endfunction

  function automatic void model_strobe(input logic [2:0] m, input logic [47:0] f,
                                       input logic [13:0] p, input logic [9:0] a);
    if (m[0]) m_f = f;
    if (m[1]) m_p = p;
    if (m[2]) m_a = a;
    m_pend = m_pend | m;
  endfunction

  // emit the highest-priority pending field (freq, then phase, then amp)
  function automatic void model_issue();
    for (int k = 0; k < 3; k++) begin
      if (m_pend[k]) begin
        exp_q.push_back(exp_frame(k));
        m_pend[k] = 1'b0;
        return;
      end
    end
  endfunction

  function automatic void model_flush();
    while (m_pend != 3'b000) model_issue();
  endfunction

  task automatic strobe(input logic [2:0] m, input logic [47:0] f,
                        input logic [13:0] p, input logic [9:0] a);
    @(negedge clk_in);
    freq_in = f; phase_in = p; amp_in = a;
    freq_dv_in = m[0]; phase_dv_in = m[1]; amp_dv_in = m[2];
    @(negedge clk_in);
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0;
  endtask

  task automatic begin_scn();
    iou_base = iou_pulses;
    min_gap = 1000;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_scn(input string tag);
    int unsigned n = 0;
    while (!(iou_pulses != iou_base && !busy_out) && n < 6000) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({tag, "_done"}, 64'(n < 6000), 64'd1);
    repeat (40) @(posedge clk_in);
    #1;
    chk({tag, "_iou_count"}, 64'(iou_pulses - iou_base), 64'd1);
    chk({tag, "_iou_width"}, 64'(iou_last_w), 64'd4);
    chk({tag, "_iou_after_frames"}, 64'(frames_at_iou), 64'(exp_q.size()));
    chk({tag, "_frame_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s_bits%0d", tag, i), 64'(got_q[i].nbits), 64'(exp_q[i].nbits));
      chk($sformatf("%s_csb_low%0d", tag, i), 64'(got_q[i].low_len), 64'(exp_q[i].low_len));
    end
    if (exp_q.size() > 1) chk({tag, "_csb_gap_ge8"}, 64'(min_gap >= 8), 64'd1);
    chk({tag, "_sdio_stable"}, 64'(viol), 64'd0);
  endtask

  task automatic count_reset_hold(input string tag);
    int unsigned n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (reset_out && n < 1000);
    chk({tag, "_reset_hold"}, 64'(n), 64'd64);
    n = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
    end while (busy_out && n < 1000);
    chk({tag, "_init_wait"}, 64'(n), 64'd256);
  endtask

  initial begin
    logic [2:0]  m;
    logic [47:0] fv;
    logic [13:0] pv;
    logic [9:0]  av;
    int unsigned n, falls0, iou0;

    reset_in = 1; freq_in = '0; phase_in = '0; amp_in = '0;
    freq_dv_in = 0; phase_dv_in = 0; amp_dv_in = 0; fast_dv = 0; zero1 = 0;
    m_f = '0; m_p = '0; m_a = '0; m_pend = '0;
    #2 reset_in = 0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_reset_out", 64'(reset_out), 64'd1);
    chk("rst_csb", 64'(csb_out), 64'd1);
    chk("rst_sclk", 64'(sclk_out), 64'd0);
    chk("rst_sdio", 64'(sdio_out), 64'd0);
    chk("rst_iou", 64'(io_update_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd1);

    @(negedge clk_in);
    reset_in = 1;
    count_reset_hold("powerup");
    chk("powerup_no_csb", 64'(csb_falls), 64'd0);

    // single frequency word with the k+2 chip-select latency
    begin_scn();
    model_strobe(3'b001, 48'h1234_5678_9ABC, '0, '0);
    model_flush();
    @(negedge clk_in);
    freq_in = 48'h1234_5678_9ABC; freq_dv_in = 1;
    @(posedge clk_in); #1;
    chk("lat_k_csb", 64'(csb_out), 64'd1);
    @(negedge clk_in);
    freq_dv_in = 0;
    @(posedge clk_in); #1;
    chk("lat_k1_csb", 64'(csb_out), 64'd1);
    @(posedge clk_in); #1;
    chk("lat_k2_csb", 64'(csb_out), 64'd0);
    finish_scn("freq1");

    // all three fields in one cycle
    begin_scn();
    fv = {16'($urandom), 32'($urandom)};
    model_strobe(3'b111, fv, 14'h1555, 10'h3FF);
    model_flush();
    strobe(3'b111, fv, 14'h1555, 10'h3FF);
    finish_scn("triple");

    // updates during an in-flight frequency shift; phase written twice (last wins)
    begin_scn();
    fv = {16'($urandom), 32'($urandom)};
    model_strobe(3'b001, fv, '0, '0);
    model_issue();
    strobe(3'b001, fv, '0, '0);
    n = 0;
    while (csb_out && n < 100) begin @(posedge clk_in); #1; n++; end
    chk("midshift_start", 64'(n < 100), 64'd1);
    repeat (100) @(posedge clk_in);
    pv = 14'($urandom);
    model_strobe(3'b001, 48'h0000_0000_0001, '0, '0);
    strobe(3'b001, 48'h0000_0000_0001, '0, '0);
    model_strobe(3'b010, '0, pv, '0);
    strobe(3'b010, '0, pv, '0);
    pv = 14'($urandom);
    model_strobe(3'b010, '0, pv, '0);
    strobe(3'b010, '0, pv, '0);
    model_flush();
    finish_scn("midshift");

    for (int it = 0; it < 5; it++) begin
      begin_scn();
      m  = 3'($urandom_range(1, 7));
      fv = {16'($urandom), 32'($urandom)};
      pv = 14'($urandom);
      av = 10'($urandom);
      model_strobe(m, fv, pv, av);
      model_flush();
      strobe(m, fv, pv, av);
      finish_scn($sformatf("rand%0d", it));
    end

    // reset pulse in the middle of a phase write
    begin_scn();
    falls0 = csb_falls;
    iou0 = iou_pulses;
    strobe(3'b010, '0, 14'h2AAA, '0);
    n = 0;
    while (csb_out && n < 100) begin @(posedge clk_in); #1; n++; end
    chk("abort_start", 64'(n < 100), 64'd1);
    repeat (60) @(posedge clk_in);
    #2 reset_in = 0;
    #1;
    chk("abort_csb", 64'(csb_out), 64'd1);
    chk("abort_sclk", 64'(sclk_out), 64'd0);
    chk("abort_reset_out", 64'(reset_out), 64'd1);
    chk("abort_iou", 64'(io_update_out), 64'd0);
    @(posedge clk_in);
    #2 reset_in = 1;
    count_reset_hold("abort");
    repeat (60) @(posedge clk_in);
    #1;
    chk("abort_no_resend", 64'(csb_falls - falls0), 64'd1);
    chk("abort_no_iou", 64'(iou_pulses - iou0), 64'd0);
    chk("abort_no_frame", 64'(got_q.size()), 64'd0);

    // SCLK_DIV=1 instance
    fv = {16'($urandom), 32'($urandom)};
    @(negedge clk_in);
    freq_in = fv; fast_dv = 1;
    @(negedge clk_in);
    fast_dv = 0;
    n = 0;
    while (f_frames == 0 && n < 1000) begin @(posedge clk_in); #1; n++; end
    chk("fast_done", 64'(n < 1000), 64'd1);
    chk("fast_data", fcur, {16'h61AB, fv});
    chk("fast_bits", 64'(fbits), 64'd64);
    chk("fast_csb_low", 64'(flow), 64'd129);
    chk("fast_sclk_period", 64'(fper_bad), 64'd0);
    chk("fast_sdio_stable", 64'(fviol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
